spi_write_arbiter: RTL and testbench
====================================

Name: spi_write_arbiter

Overview:
- Shares one mkSPIWriter byte-serialiser among NUM_REQ independent requesters.
- Arbitration is round-robin.
- Issues exactly one EN_write pulse per accepted byte and tracks the writer's busy period through RDY_write.
- Holds an owner select, valid from issue until the byte completes, so board logic can steer the writer's spi chip-select to the correct target.
- Sits between the requesting engines and the writer's write/EN_write/RDY_write method ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match writer write_data.
- BUSY_TIMEOUT, 4, max cycles to wait for RDY_write to fall after an issue.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte pending.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot acceptance pulse; byte i is taken when req_valid[i] & req_ready[i].
- wr_data  out  DATA_W  to writer write_data.
- wr_en  out  1  to writer EN_write.
- wr_rdy  in  1  from writer RDY_write.
- owner_sel  out  NUM_REQ  one-hot owner; all-zero when idle.
- owner_id  out  clog2(NUM_REQ)  binary owner index.
- busy  out  1  high from accept until done.
- done_pulse  out  1  one cycle when the owned byte completes.
- timeout_err  out  1  sticky; set when the busy-wait times out.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; all outputs 0.
  - rr_ptr=0, so requester 0 has highest priority first.
  - Reset mid-transfer abandons the byte. No done_pulse is issued.
- IDLE:
  - If any req_valid and wr_rdy=1, grant the first requester at or after rr_ptr (circular search).
  - Same cycle (combinational): req_ready[g]=1, wr_en=1, wr_data=req_data[g].
  - Next edge: latch owner, busy=1, rr_ptr=(g+1) mod NUM_REQ, go WAIT_BUSY.
  - If wr_rdy=0: no grant; req_ready=0.
- wr_en is asserted only when wr_rdy=1, never otherwise, and only in IDLE. It is one cycle per accepted byte.
- WAIT_BUSY: wait for wr_rdy=0, then go WAIT_DONE.
  - The bounded counter counts from 1.
  - If BUSY_TIMEOUT cycles elapse with wr_rdy still high: set timeout_err, treat the byte as complete, go DONE.
- WAIT_DONE: wait for wr_rdy=1, then go DONE. No timeout, since SPI duration depends on the writer.
- DONE (1 cycle):
  - done_pulse=1; owner_sel and owner_id still valid.
  - Next edge: busy=0, owner_sel=0, go IDLE.
  - A new grant cannot occur in the DONE cycle, so there is a minimum 1 idle cycle between bytes. This guarantees a chip-select deassert gap.
- owner_sel and owner_id are registered and constant from WAIT_BUSY through DONE.
- req_valid may drop at any time without acceptance. Requesters are not required to hold data, but must not change req_data during their own accept cycle.
- Simultaneous requests: only one grant per accept. Losers keep req_valid and are served in rotation. With all requesters continuously valid, service order is 0,1,2,3,0,...
- err_clr has priority over a new timeout set in the same cycle? No: set wins. A clear and a set in the same cycle leave timeout_err=1.
- NUM_REQ not a power of two: rr_ptr wraps at NUM_REQ-1 to 0.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding: IDLE=0, WAIT_BUSY=1, WAIT_DONE=2, DONE=3
  - SPI_DATA_W=8
  - the clog2 helper function
- One natural sub-module: rr_arbiter.
  - Combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, binary index, any.
  - Reused later by other shared-peripheral controllers.

Test Plan:
1. Reset: RST_N low for 3 cycles while req_valid=4'b1111 -> wr_en=0, req_ready=0, owner_sel=0, busy=0. After release with wr_rdy=1 -> first grant to requester 0.
2. Single request: req_valid=4'b0100, data2=8'd101, wr_rdy=1 -> same cycle wr_en=1, wr_data=101, req_ready=4'b0100. owner_id=2 until done_pulse.
3. Writer model: drop wr_rdy 1 cycle after wr_en, hold low 16 cycles -> done_pulse exactly 1 cycle after wr_rdy rises; next wr_en no earlier than 2 cycles after that rise.
4. Contention: all four valid with data 8'd10/20/30/40 -> writer receives 10,20,30,40,10. Each wr_en occurs with wr_rdy=1; never two wr_en inside one busy window.
5. Timeout: writer keeps wr_rdy=1 after wr_en -> after 4 cycles timeout_err=1 and done_pulse=1. Pulse err_clr -> timeout_err=0; simultaneous new timeout keeps it 1.
6. Reset mid-transfer: RST_N low during WAIT_DONE -> outputs 0 immediately (asynchronous), no done_pulse. After release, rr_ptr=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI write arbiter and related shared-peripheral controllers.
package spi_pkg;

    // Byte width of the mkSPIWriter write_data method argument.
    localparam int unsigned SPI_DATA_W = 8;

    // Arbiter FSM encoding; values are fixed so they stay stable across controllers.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitBusy = 2'd1,
        StWaitDone = 2'd2,
        StDone     = 2'd3
    } arb_state_e;

    // Ceiling log2 with a floor of 1 so index fields never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/spi_write_arbiter_if.sv
// Requester and writer-side signal bundle for spi_write_arbiter.
interface spi_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = spi_pkg::SPI_DATA_W
);
    import spi_pkg::*;

    localparam int unsigned ID_W = clog2(NUM_REQ);

    // Requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    // Writer method ports
    logic [DATA_W-1:0]         wr_data;
    logic                      wr_en;
    logic                      wr_rdy;

    // Ownership and status
    logic [NUM_REQ-1:0]        owner_sel;
    logic [ID_W-1:0]           owner_id;
    logic                      busy;
    logic                      done_pulse;
    logic                      timeout_err;
    logic                      err_clr;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, wr_rdy, err_clr,
        output req_ready, wr_data, wr_en, owner_sel, owner_id, busy, done_pulse, timeout_err
    );

    // Requesters, writer and board logic side
    modport master (
        output req_valid, req_data, wr_rdy, err_clr,
        input  req_ready, wr_data, wr_en, owner_sel, owner_id, busy, done_pulse, timeout_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, circularly.
module rr_arbiter import spi_pkg::*; #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdW    = clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdW-1:0]    idx_o,
    output logic              any_o
);

    // Walk the requests starting at the pointer, wrapping at NumReq-1 (not at 2**IdW-1).
    always_comb begin
        int unsigned k;
        logic [IdW-1:0] kk;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        kk    = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            k = 32'(ptr_i) + off;
            if (k >= NumReq) begin
                k = k - NumReq;
            end
            kk = IdW'(k);
            if (!any_o && req_i[kk]) begin
                any_o     = 1'b1;
                gnt_o[kk] = 1'b1;
                idx_o     = kk;
            end
        end
    end

endmodule

// File: rtl/spi_write_arbiter.sv
// Shares one mkSPIWriter byte serialiser among NUM_REQ requesters with round-robin arbitration.
// One EN_write per accepted byte; the writer's busy period is tracked through RDY_write.
module spi_write_arbiter import spi_pkg::*; #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = SPI_DATA_W,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    spi_write_arbiter_if.slave bus
);

    localparam int unsigned ID_W  = clog2(NUM_REQ);
    localparam int unsigned CNT_W = clog2(BUSY_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] owner_sel_q, owner_sel_d;
    logic [ID_W-1:0]    owner_id_q, owner_id_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               set_timeout;
    // Holds off grants until the first edge after reset release so all outputs stay 0 in reset.
    logic               armed_q;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               issue;
    logic [ID_W-1:0]    next_ptr;

    rr_arbiter #(
        .NumReq (NUM_REQ),
        .IdW    (ID_W)
    ) u_rr_arbiter (
        .req_i  (bus.req_valid),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // A byte is accepted only from IDLE while the writer reports ready.
    assign issue    = armed_q && (state_q == StIdle) && bus.wr_rdy && gnt_any;
    assign next_ptr = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    // Same-cycle acceptance: ready pulse, EN_write and the granted byte.
    assign bus.req_ready = issue ? gnt : '0;
    assign bus.wr_en     = issue;
    assign bus.wr_data   = issue ? bus.req_data[gnt_idx*DATA_W +: DATA_W] : '0;

    assign bus.owner_sel   = owner_sel_q;
    assign bus.owner_id    = owner_id_q;
    assign bus.busy        = busy_q;
    assign bus.done_pulse  = (state_q == StDone);
    assign bus.timeout_err = timeout_q;

    // Next-state logic for the issue / busy-wait / completion sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_sel_d = owner_sel_q;
        owner_id_d  = owner_id_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        set_timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d     = StWaitBusy;
                    owner_sel_d = gnt;
                    owner_id_d  = gnt_idx;
                    busy_d      = 1'b1;
                    rr_ptr_d    = next_ptr;
                    cnt_d       = CNT_W'(1);
                end
            end
            StWaitBusy: begin
                if (!bus.wr_rdy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT)) begin
                    // Writer never went busy: flag it and retire the byte anyway.
                    set_timeout = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitDone: begin
                if (bus.wr_rdy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d     = StIdle;
                busy_d      = 1'b0;
                owner_sel_d = '0;
                owner_id_d  = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sticky timeout flag; a new timeout wins over a same-cycle clear.
    always_comb begin
        timeout_d = (timeout_q & ~bus.err_clr) | set_timeout;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            owner_sel_q <= '0;
            owner_id_q  <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_sel_q <= owner_sel_d;
            owner_id_q  <= owner_id_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            armed_q     <= 1'b1;
        end
    end

    // Protocol properties on the writer and requester handshakes.
    a_en_needs_rdy: assert property (@(posedge CLK) disable iff (!RST_N)
        bus.wr_en |-> bus.wr_rdy);
    a_ready_onehot: assert property (@(posedge CLK) disable iff (!RST_N)
        $onehot0(bus.req_ready));
    a_owner_onehot: assert property (@(posedge CLK) disable iff (!RST_N)
        $onehot0(bus.owner_sel));
    a_en_single: assert property (@(posedge CLK) disable iff (!RST_N)
        bus.wr_en |=> !bus.wr_en);

endmodule

// File: tb/tb_spi_write_arbiter.sv
// Directed bench for spi_write_arbiter with a scoreboard monitor on the writer port.
module tb_spi_write_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 8;

    typedef struct {
        int unsigned id;
        logic [7:0]  data;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    spi_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus_if ();

    spi_write_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .BUSY_TIMEOUT (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_if)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expectation on every wr_en, checks owner at done_pulse.
    bit          inflight = 1'b0;
    int unsigned mon_id   = 0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            inflight = 1'b0;
        end else begin
            if (bus_if.wr_en) begin
                exp_t e;
                check("en_with_rdy", 32'(bus_if.wr_rdy), 1);
                check("en_not_busy", 32'(bus_if.busy), 0);
                check("en_no_overlap", 32'(inflight), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_data", 32'(bus_if.wr_data), 32'(e.data));
                    check("req_ready", 32'(bus_if.req_ready), 32'd1 << e.id);
                    mon_id   = e.id;
                    inflight = 1'b1;
                end
            end
            if (bus_if.done_pulse) begin
                check("done_has_owner", 32'(inflight), 1);
                check("done_owner_id", 32'(bus_if.owner_id), mon_id);
                inflight = 1'b0;
            end
        end
    end

    task automatic wait_en();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (bus_if.wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_wr_en", 32'(ok), 1);
    endtask

    // Normal writer: RDY_write low for busy_len cycles after the accept edge.
    task automatic serve_byte(input int unsigned id, input int unsigned busy_len, input bit clr);
        wait_en();
        @(posedge CLK);
        #1;
        if (clr) bus_if.req_valid = '0;
        bus_if.wr_rdy = 1'b0;
        for (int i = 0; i < int'(busy_len); i++) begin
            @(negedge CLK);
            check("busy_high", 32'(bus_if.busy), 1);
            check("busy_no_en", 32'(bus_if.wr_en), 0);
            check("busy_owner_id", 32'(bus_if.owner_id), id);
        end
        @(posedge CLK);
        #1 bus_if.wr_rdy = 1'b1;
        @(negedge CLK);
        check("rise_no_done", 32'(bus_if.done_pulse), 0);
        check("rise_no_en", 32'(bus_if.wr_en), 0);
        @(negedge CLK);
        check("done_pulse", 32'(bus_if.done_pulse), 1);
        check("done_owner_sel", 32'(bus_if.owner_sel), 32'd1 << id);
        check("done_no_en", 32'(bus_if.wr_en), 0);
    endtask

    // Stuck writer: RDY_write never falls, so the busy-wait must time out.
    task automatic serve_stuck(input int unsigned id, input bit clr_same);
        wait_en();
        @(posedge CLK);
        #1 bus_if.req_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4 && clr_same) bus_if.err_clr = 1'b1;
            @(negedge CLK);
            check("to_wait_no_done", 32'(bus_if.done_pulse), 0);
            check("to_wait_no_err", 32'(bus_if.timeout_err), 0);
            check("to_wait_busy", 32'(bus_if.busy), 1);
            @(posedge CLK);
            #1;
        end
        bus_if.err_clr = 1'b0;
        @(negedge CLK);
        check("to_done_pulse", 32'(bus_if.done_pulse), 1);
        check("to_err_set", 32'(bus_if.timeout_err), 1);
        check("to_done_owner", 32'(bus_if.owner_id), id);
        @(negedge CLK);
        check("to_idle_busy", 32'(bus_if.busy), 0);
        check("to_idle_sel", 32'(bus_if.owner_sel), 0);
        check("to_err_sticky", 32'(bus_if.timeout_err), 1);
        @(posedge CLK);
        #1 bus_if.err_clr = 1'b1;
        @(posedge CLK);
        #1 bus_if.err_clr = 1'b0;
        @(negedge CLK);
        check("err_cleared", 32'(bus_if.timeout_err), 0);
    endtask

    initial begin
        RST_N            = 1'b0;
        bus_if.req_valid = 4'b1111;
        bus_if.req_data  = {8'd40, 8'd30, 8'd20, 8'd10};
        bus_if.wr_rdy    = 1'b1;
        bus_if.err_clr   = 1'b0;

        // Reset with all requesters pending
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_wr_en", 32'(bus_if.wr_en), 0);
        check("rst_req_ready", 32'(bus_if.req_ready), 0);
        check("rst_owner_sel", 32'(bus_if.owner_sel), 0);
        check("rst_busy", 32'(bus_if.busy), 0);
        check("rst_timeout", 32'(bus_if.timeout_err), 0);

        // Contention: expected order 0,1,2,3,0
        exp_q.push_back('{id: 0, data: 8'd10});
        exp_q.push_back('{id: 1, data: 8'd20});
        exp_q.push_back('{id: 2, data: 8'd30});
        exp_q.push_back('{id: 3, data: 8'd40});
        exp_q.push_back('{id: 0, data: 8'd10});
        @(posedge CLK);
        #1 RST_N = 1'b1;
        serve_byte(0, 16, 1'b0);
        serve_byte(1, 16, 1'b0);
        serve_byte(2, 16, 1'b0);
        serve_byte(3, 16, 1'b0);
        serve_byte(0, 16, 1'b1);

        // Writer not ready: no grant
        @(posedge CLK);
        #1;
        bus_if.wr_rdy            = 1'b0;
        bus_if.req_data[23:16]   = 8'd101;
        bus_if.req_valid         = 4'b0100;
        repeat (2) begin
            @(negedge CLK);
            check("nordy_no_en", 32'(bus_if.wr_en), 0);
            check("nordy_no_ready", 32'(bus_if.req_ready), 0);
        end

        // Single request from requester 2
        @(posedge CLK);
        #1;
        exp_q.push_back('{id: 2, data: 8'd101});
        bus_if.wr_rdy = 1'b1;
        serve_byte(2, 16, 1'b1);

        // Timeout, then timeout with a same-cycle clear
        @(posedge CLK);
        #1;
        exp_q.push_back('{id: 0, data: 8'd10});
        bus_if.req_valid = 4'b0001;
        serve_stuck(0, 1'b0);
        @(posedge CLK);
        #1;
        exp_q.push_back('{id: 0, data: 8'd10});
        bus_if.req_valid = 4'b0001;
        serve_stuck(0, 1'b1);

        // Reset during WAIT_DONE
        @(posedge CLK);
        #1;
        exp_q.push_back('{id: 1, data: 8'd20});
        bus_if.req_valid = 4'b1111;
        wait_en();
        @(posedge CLK);
        #1;
        bus_if.req_valid = '0;
        bus_if.wr_rdy    = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus_if.busy), 0);
        check("mid_rst_sel", 32'(bus_if.owner_sel), 0);
        check("mid_rst_id", 32'(bus_if.owner_id), 0);
        check("mid_rst_done", 32'(bus_if.done_pulse), 0);
        check("mid_rst_en", 32'(bus_if.wr_en), 0);
        repeat (2) @(posedge CLK);
        #1;
        bus_if.wr_rdy    = 1'b1;
        bus_if.req_valid = 4'b1111;
        exp_q.push_back('{id: 0, data: 8'd10});
        RST_N = 1'b1;
        serve_byte(0, 16, 1'b1);

        repeat (5) @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 0);
        check("end_busy", 32'(bus_if.busy), 0);
        check("end_timeout", 32'(bus_if.timeout_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
